async_sram_ctrl: RTL and testbench

ASYNC_SRAM_CTRL -- requirements
Module: async_sram_ctrl

---
 rtl/async_sram_ctrl_if.sv | 24 ++
 rtl/async_sram_ctrl.sv | 179 +++++++++++++++++
 tb/tb_async_sram_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/async_sram_ctrl_if.sv
// Request/response channel between a client and async_sram_ctrl.
// The client side uses the master modport; the controller uses the slave modport.
interface async_sram_ctrl_if #(
    parameter int N_SRAM_A  = 18,
    parameter int N_SRAM_DQ = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [N_SRAM_A-1:0]  req_addr;
    logic [N_SRAM_DQ-1:0] req_wdata;
    logic                 rsp_valid;
    logic [N_SRAM_DQ-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/async_sram_ctrl.sv
// Single-transfer controller for an asynchronous SRAM behind a registered PHY; every output is a flop.
// Build macro ASYNC_SRAM_CTRL_RD_PIPE_EN lets a new request be accepted while a read is in RD_WAIT.
module async_sram_ctrl #(
    parameter int N_SRAM_A  = 18,
    parameter int N_SRAM_DQ = 16,
    parameter int RD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    async_sram_ctrl_if.slave     bus,
    output logic [N_SRAM_A-1:0]  ctrl_addr,
    output logic [N_SRAM_DQ-1:0] ctrl_dq_out,
    output logic [N_SRAM_DQ-1:0] ctrl_dq_oe,
    output logic                 ctrl_ce_n,
    output logic                 ctrl_we_n,
    output logic                 ctrl_oe_n,
    input  logic [N_SRAM_DQ-1:0] ctrl_dq_in
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        TURN    = 3'd3,
        WR      = 3'd4,
        WR_HOLD = 3'd5
    } state_t;

    localparam logic [2:0] RD_LAST_C = 3'(RD_CYCLES);

    state_t               state_r, state_nxt_s;
    logic [2:0]           rd_cnt_r, rd_cnt_nxt_s;
    logic                 accept_s;

    logic                 req_ready_r, req_ready_nxt_s;
    logic                 rsp_valid_r, rsp_valid_nxt_s;
    logic [N_SRAM_DQ-1:0] rsp_rdata_r, rsp_rdata_nxt_s;
    logic [N_SRAM_A-1:0]  ctrl_addr_r, ctrl_addr_nxt_s;
    logic [N_SRAM_DQ-1:0] ctrl_dq_out_r, ctrl_dq_out_nxt_s;
    logic [N_SRAM_DQ-1:0] ctrl_dq_oe_r, ctrl_dq_oe_nxt_s;
    logic                 ctrl_ce_n_r, ctrl_ce_n_nxt_s;
    logic                 ctrl_we_n_r, ctrl_we_n_nxt_s;
    logic                 ctrl_oe_n_r, ctrl_oe_n_nxt_s;

    assign accept_s      = bus.req_valid & req_ready_r;
    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign ctrl_addr     = ctrl_addr_r;
    assign ctrl_dq_out   = ctrl_dq_out_r;
    assign ctrl_dq_oe    = ctrl_dq_oe_r;
    assign ctrl_ce_n     = ctrl_ce_n_r;
    assign ctrl_we_n     = ctrl_we_n_r;
    assign ctrl_oe_n     = ctrl_oe_n_r;

    // State and read-length counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            rd_cnt_r <= 3'd0;
        end else begin
            state_r  <= state_nxt_s;
            rd_cnt_r <= rd_cnt_nxt_s;
        end
    end

    // Next-state logic; rd_cnt_r counts RD cycles already spent, starting at 1.
    always_comb begin
        state_nxt_s  = state_r;
        rd_cnt_nxt_s = rd_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s  = bus.req_write ? WR : RD;
                    rd_cnt_nxt_s = 3'd1;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            RD: begin
                if (rd_cnt_r >= RD_LAST_C) begin
                    state_nxt_s  = RD_WAIT;
                end else begin
                    rd_cnt_nxt_s = rd_cnt_r + 3'd1;
                end
            end
            RD_WAIT: begin
`ifdef ASYNC_SRAM_CTRL_RD_PIPE_EN
                if (accept_s) begin
                    state_nxt_s  = bus.req_write ? TURN : RD;
                    rd_cnt_nxt_s = 3'd1;
                end else begin
                    state_nxt_s  = IDLE;
                end
`else
                state_nxt_s = IDLE;
`endif
            end
            TURN:    state_nxt_s = WR;
            WR:      state_nxt_s = WR_HOLD;
            WR_HOLD: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: values for the coming cycle, derived from the state being entered.
    always_comb begin
        ctrl_ce_n_nxt_s   = 1'b1;
        ctrl_we_n_nxt_s   = 1'b1;
        ctrl_oe_n_nxt_s   = 1'b1;
        ctrl_dq_oe_nxt_s  = {N_SRAM_DQ{1'b0}};
        case (state_nxt_s)
            RD: begin
                ctrl_ce_n_nxt_s = 1'b0;
                ctrl_oe_n_nxt_s = 1'b0;
            end
            WR: begin
                ctrl_ce_n_nxt_s  = 1'b0;
                ctrl_we_n_nxt_s  = 1'b0;
                ctrl_dq_oe_nxt_s = {N_SRAM_DQ{1'b1}};
            end
            WR_HOLD: begin
                ctrl_ce_n_nxt_s  = 1'b0;
                ctrl_dq_oe_nxt_s = {N_SRAM_DQ{1'b1}};
            end
            default: begin
                ctrl_ce_n_nxt_s = 1'b1;
            end
        endcase

`ifdef ASYNC_SRAM_CTRL_RD_PIPE_EN
        req_ready_nxt_s = (state_nxt_s == IDLE) || (state_nxt_s == RD_WAIT);
`else
        req_ready_nxt_s = (state_nxt_s == IDLE);
`endif

        // Address and write data are captured only at acceptance and then held.
        if (accept_s) begin
            ctrl_addr_nxt_s   = bus.req_addr;
            ctrl_dq_out_nxt_s = bus.req_write ? bus.req_wdata : ctrl_dq_out_r;
        end else begin
            ctrl_addr_nxt_s   = ctrl_addr_r;
            ctrl_dq_out_nxt_s = ctrl_dq_out_r;
        end

        rsp_valid_nxt_s = (state_r == RD_WAIT);
        if (state_r == RD_WAIT) begin
            rsp_rdata_nxt_s = ctrl_dq_in;
        end else begin
            rsp_rdata_nxt_s = rsp_rdata_r;
        end
    end

    // Output register; the async clear releases ctrl_we_n and the data bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {N_SRAM_DQ{1'b0}};
            ctrl_addr_r   <= {N_SRAM_A{1'b0}};
            ctrl_dq_out_r <= {N_SRAM_DQ{1'b0}};
            ctrl_dq_oe_r  <= {N_SRAM_DQ{1'b0}};
            ctrl_ce_n_r   <= 1'b1;
            ctrl_we_n_r   <= 1'b1;
            ctrl_oe_n_r   <= 1'b1;
        end else begin
            req_ready_r   <= req_ready_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_rdata_r   <= rsp_rdata_nxt_s;
            ctrl_addr_r   <= ctrl_addr_nxt_s;
            ctrl_dq_out_r <= ctrl_dq_out_nxt_s;
            ctrl_dq_oe_r  <= ctrl_dq_oe_nxt_s;
            ctrl_ce_n_r   <= ctrl_ce_n_nxt_s;
            ctrl_we_n_r   <= ctrl_we_n_nxt_s;
            ctrl_oe_n_r   <= ctrl_oe_n_nxt_s;
        end
    end

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Bench for async_sram_ctrl: directed and random requests against a cycle timeline built from the
// transfer rules, with a registered-PHY plus SRAM model answering reads.
module tb_async_sram_ctrl;

    localparam int NA   = 18;
    localparam int NDQ  = 16;
    localparam int RD   = 2;
    localparam int MAXC = 2048;
`ifdef ASYNC_SRAM_CTRL_RD_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [NA-1:0]  ctrl_addr;
    logic [NDQ-1:0] ctrl_dq_out, ctrl_dq_oe, ctrl_dq_in;
    logic           ctrl_ce_n, ctrl_we_n, ctrl_oe_n;

    always #5 clk = ~clk;

    async_sram_ctrl_if #(.N_SRAM_A(NA), .N_SRAM_DQ(NDQ)) bus ();

    async_sram_ctrl #(.N_SRAM_A(NA), .N_SRAM_DQ(NDQ), .RD_CYCLES(RD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ctrl_addr   (ctrl_addr),
        .ctrl_dq_out (ctrl_dq_out),
        .ctrl_dq_oe  (ctrl_dq_oe),
        .ctrl_ce_n   (ctrl_ce_n),
        .ctrl_we_n   (ctrl_we_n),
        .ctrl_oe_n   (ctrl_oe_n),
        .ctrl_dq_in  (ctrl_dq_in)
    );

    bit [NDQ-1:0] sram_mem [bit [NA-1:0]];
    bit [NDQ-1:0] ref_mem  [bit [NA-1:0]];

    // PHY + SRAM: writes land on the clock edge, read data appears one cycle after the pad.
    always @(posedge clk) begin
        if (ctrl_ce_n === 1'b0 && ctrl_we_n === 1'b0) sram_mem[ctrl_addr] = ctrl_dq_out;
        if (ctrl_ce_n === 1'b0 && ctrl_oe_n === 1'b0)
            ctrl_dq_in <= sram_mem.exists(ctrl_addr) ? sram_mem[ctrl_addr] : 16'h0000;
        else
            ctrl_dq_in <= NDQ'($urandom);
    end

    // Expected per-cycle behaviour, filled in when the model accepts a request.
    bit             exp_busy  [MAXC];
    bit             exp_rdwait[MAXC];
    bit             exp_ce_lo [MAXC];
    bit             exp_oe_lo [MAXC];
    bit             exp_we_lo [MAXC];
    bit             exp_dqoe  [MAXC];
    bit             exp_rsp   [MAXC];
    logic [NDQ-1:0] exp_rsp_d [MAXC];

    int             cyc, n_vec, n_err;
    logic [NA-1:0]  last_addr, wr_pend_addr;
    logic [NDQ-1:0] last_wdata, last_rdata, wr_pend_old;
    bit             prev_oe_lo;
    int             wr_done_cyc;
    logic [NA-1:0]  pool [8];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [NDQ-1:0] ref_rd(input logic [NA-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic check_cycle();
        if (exp_rsp[cyc]) last_rdata = exp_rsp_d[cyc];
        chk_eq("req_ready", 32'(bus.req_ready), 32'(!exp_busy[cyc]));
        chk_eq("ce_n",      32'(ctrl_ce_n),     32'(!exp_ce_lo[cyc]));
        chk_eq("oe_n",      32'(ctrl_oe_n),     32'(!exp_oe_lo[cyc]));
        chk_eq("we_n",      32'(ctrl_we_n),     32'(!exp_we_lo[cyc]));
        chk_eq("dq_oe",     32'(ctrl_dq_oe),    exp_dqoe[cyc] ? 32'h0000FFFF : 32'h0);
        chk_eq("addr",      32'(ctrl_addr),     32'(last_addr));
        chk_eq("dq_out",    32'(ctrl_dq_out),   32'(last_wdata));
        chk_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp[cyc]));
        chk_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(last_rdata));
        chk_eq("we_oe_excl", 32'(ctrl_we_n | ctrl_oe_n), 32'd1);
        chk_eq("dq_oe_near_oe", (!ctrl_oe_n || prev_oe_lo) ? 32'(ctrl_dq_oe) : 32'd0, 32'd0);
        prev_oe_lo = !ctrl_oe_n;
    endtask

    // One clock cycle: check, drive, record acceptance in the timeline, advance to next negedge.
    task automatic step(input bit v, input bit w, input logic [NA-1:0] a,
                        input logic [NDQ-1:0] d, output bit acc);
        int sh;
        check_cycle();
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        acc = v && !exp_busy[cyc];
        if (acc) begin
            last_addr = a;
            if (w) begin
                sh = (PIPE && exp_rdwait[cyc]) ? 1 : 0;
                last_wdata = d;
                for (int k = 1; k <= 2 + sh; k++) exp_busy[cyc+k] = 1'b1;
                for (int k = 1; k <= 2; k++) begin
                    exp_ce_lo[cyc+k+sh] = 1'b1;
                    exp_dqoe[cyc+k+sh]  = 1'b1;
                end
                exp_we_lo[cyc+1+sh] = 1'b1;
                wr_pend_addr = a;
                wr_pend_old  = ref_rd(a);
                wr_done_cyc  = cyc + 1 + sh;
                ref_mem[a]   = d;
            end else begin
                for (int k = 1; k <= RD; k++) begin
                    exp_busy[cyc+k]  = 1'b1;
                    exp_ce_lo[cyc+k] = 1'b1;
                    exp_oe_lo[cyc+k] = 1'b1;
                end
                exp_rdwait[cyc+RD+1] = 1'b1;
                if (!PIPE) exp_busy[cyc+RD+1] = 1'b1;
                exp_rsp[cyc+RD+2]   = 1'b1;
                exp_rsp_d[cyc+RD+2] = ref_rd(a);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), NA'($urandom), NDQ'($urandom), acc);
    endtask

    // Hold a request until the model accepts it; acceptance always comes within a few cycles.
    task automatic xfer(input bit w, input logic [NA-1:0] a, input logic [NDQ-1:0] d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 16 && !acc; i++) step(1'b1, w, a, d, acc);
        chk_eq("xfer_accepted", 32'(acc), 32'd1);
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_ce_n",      32'(ctrl_ce_n),     32'd1);
        chk_eq("rst_we_n",      32'(ctrl_we_n),     32'd1);
        chk_eq("rst_oe_n",      32'(ctrl_oe_n),     32'd1);
        chk_eq("rst_dq_oe",     32'(ctrl_dq_oe),    32'd0);
        chk_eq("rst_addr",      32'(ctrl_addr),     32'd0);
        chk_eq("rst_dq_out",    32'(ctrl_dq_out),   32'd0);
        chk_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk_eq("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        if (wr_done_cyc >= cyc) ref_mem[wr_pend_addr] = wr_pend_old;
        for (int c = cyc; c < MAXC; c++) begin
            exp_busy[c] = 1'b0; exp_rdwait[c] = 1'b0; exp_ce_lo[c] = 1'b0; exp_oe_lo[c] = 1'b0;
            exp_we_lo[c] = 1'b0; exp_dqoe[c] = 1'b0; exp_rsp[c] = 1'b0;
        end
        last_addr = '0; last_wdata = '0; last_rdata = '0; prev_oe_lo = 1'b0; wr_done_cyc = -1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; wr_done_cyc = -1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        pool[0] = 18'h00000; pool[1] = 18'h00001; pool[2] = 18'h00002; pool[3] = 18'h00004;
        pool[4] = 18'h00010; pool[5] = 18'h12345; pool[6] = 18'h3FFFF; pool[7] = 18'h2AAAA;
        @(negedge clk);
        do_reset();

        xfer(1'b1, 18'h12345, 16'hBEEF);
        idle(4);
        sram_mem[18'h00010] = 16'h5A5A;
        ref_mem[18'h00010]  = 16'h5A5A;
        xfer(1'b0, 18'h00010, 16'h0000);
        idle(6);
        xfer(1'b1, 18'h00004, 16'h1111);
        xfer(1'b0, 18'h00004, 16'h0000);
        idle(6);

        // Reset lands in the WR cycle; the aborted write must not reach the SRAM.
        xfer(1'b1, 18'h00004, 16'hDEAD);
        do_reset();
        xfer(1'b0, 18'h00004, 16'h0000);
        idle(6);

        xfer(1'b0, 18'h00001, 16'h0000);
        xfer(1'b0, 18'h00002, 16'h0000);
        idle(6);
        xfer(1'b0, 18'h00001, 16'h0000);
        xfer(1'b1, 18'h00002, 16'hC3C3);
        idle(6);

        for (int i = 0; i < 1200; i++) begin
            bit acc;
            step(1'($urandom), 1'($urandom), pool[$urandom_range(0, 7)], NDQ'($urandom), acc);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
